// File: rtl/key_pkg.sv
// Shared definitions for the key conditioner.
//   key_state_e : per-channel debounce FSM state
//   DB_20MS     : 20 ms debounce window at 125 MHz
//   LONG_1S     : 1 s long-press threshold at 125 MHz
//   RPT_200MS   : 200 ms auto-repeat period at 125 MHz
package key_pkg;

    typedef enum logic [1:0] {
        KEY_IDLE      = 2'd0,
        KEY_PRESS_CHK = 2'd1,
        KEY_HELD      = 2'd2,
        KEY_REL_CHK   = 2'd3
    } key_state_e;

    localparam int DB_20MS   = 2_500_000;
    localparam int LONG_1S   = 125_000_000;
    localparam int RPT_200MS = 25_000_000;

endpackage

// File: rtl/key_debounce_chan.sv
// One key channel: 2-flop synchroniser, debounce FSM, hold / repeat timers.
// Ports:
//   clk, rst      : clock, asynchronous active-low reset
//   key           : raw asynchronous button input
//   level         : debounced pressed level (1 = pressed)
//   press_pls     : one-cycle pulse on accepted press
//   release_pls   : one-cycle pulse on accepted release
//   long_pls      : one-cycle pulse after LONG_CYCLES held
//   repeat_pls    : one-cycle pulse every REPEAT_CYCLES after long_pls
module key_debounce_chan
    import key_pkg::*;
#(
    parameter int DB_CYCLES     = DB_20MS,
    parameter int LONG_CYCLES   = LONG_1S,
    parameter int REPEAT_CYCLES = RPT_200MS,
    parameter int ACTIVE_LOW    = 0
) (
    input  logic clk,
    input  logic rst,
    input  logic key,
    output logic level,
    output logic press_pls,
    output logic release_pls,
    output logic long_pls,
    output logic repeat_pls
);

    localparam int DB_W   = ($clog2(DB_CYCLES) > 1) ? $clog2(DB_CYCLES) : 1;
    localparam int HOLD_W = ($clog2(LONG_CYCLES) > 1) ? $clog2(LONG_CYCLES) : 1;
    localparam int RPT_W  = ($clog2(REPEAT_CYCLES) > 1) ? $clog2(REPEAT_CYCLES) : 1;

    localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DB_CYCLES - 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONG_CYCLES - 1);
    localparam logic [RPT_W-1:0]  RPT_LAST  = RPT_W'((REPEAT_CYCLES > 0) ? REPEAT_CYCLES - 1 : 0);

    // Raw level of a released key; the synchroniser resets to it so that
    // leaving reset never looks like an edge.
    localparam logic REL_VAL = (ACTIVE_LOW != 0);

    logic [1:0]        sync;
    logic              p;
    key_state_e        state;
    logic [DB_W-1:0]   db_cnt;
    logic [HOLD_W-1:0] hold_cnt;
    logic [RPT_W-1:0]  rpt_cnt;
    logic              long_done;
    logic              rel_accept;
    logic              counting;

    assign p          = sync[1] ^ REL_VAL;
    assign rel_accept = (state == KEY_REL_CHK) && !p && (db_cnt == DB_LAST);
    // Hold time runs through a release check; the accepting edge clears instead.
    assign counting   = ((state == KEY_HELD) || (state == KEY_REL_CHK)) && !rel_accept;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync        <= {2{REL_VAL}};
            state       <= KEY_IDLE;
            db_cnt      <= '0;
            hold_cnt    <= '0;
            rpt_cnt     <= '0;
            long_done   <= 1'b0;
            level       <= 1'b0;
            press_pls   <= 1'b0;
            release_pls <= 1'b0;
            long_pls    <= 1'b0;
            repeat_pls  <= 1'b0;
        end else begin
            sync        <= {sync[0], key};
            press_pls   <= 1'b0;
            release_pls <= 1'b0;
            long_pls    <= 1'b0;
            repeat_pls  <= 1'b0;

            case (state)
                KEY_IDLE: begin
                    if (p) begin
                        state  <= KEY_PRESS_CHK;
                        db_cnt <= '0;
                    end
                end
                KEY_PRESS_CHK: begin
                    if (!p) begin
                        state <= KEY_IDLE;
                    end else if (db_cnt == DB_LAST) begin
                        state     <= KEY_HELD;
                        level     <= 1'b1;
                        press_pls <= 1'b1;
                        hold_cnt  <= '0;
                        rpt_cnt   <= '0;
                        long_done <= 1'b0;
                    end else begin
                        db_cnt <= db_cnt + DB_W'(1);
                    end
                end
                KEY_HELD: begin
                    if (!p) begin
                        state  <= KEY_REL_CHK;
                        db_cnt <= '0;
                    end
                end
                KEY_REL_CHK: begin
                    if (p) begin
                        state <= KEY_HELD;
                    end else if (rel_accept) begin
                        state       <= KEY_IDLE;
                        level       <= 1'b0;
                        release_pls <= 1'b1;
                        hold_cnt    <= '0;
                        rpt_cnt     <= '0;
                        long_done   <= 1'b0;
                    end else begin
                        db_cnt <= db_cnt + DB_W'(1);
                    end
                end
                default: state <= KEY_IDLE;
            endcase

            // hold_cnt parks at LONG_CYCLES-1 once long fires; long_done
            // keeps the compare from firing again.
            if (counting) begin
                if (!long_done) begin
                    if (hold_cnt == HOLD_LAST) begin
                        long_pls  <= 1'b1;
                        long_done <= 1'b1;
                        rpt_cnt   <= '0;
                    end else begin
                        hold_cnt <= hold_cnt + HOLD_W'(1);
                    end
                end else if (REPEAT_CYCLES > 0) begin
                    if (rpt_cnt == RPT_LAST) begin
                        repeat_pls <= 1'b1;
                        rpt_cnt    <= '0;
                    end else begin
                        rpt_cnt <= rpt_cnt + RPT_W'(1);
                    end
                end
            end
        end
    end

endmodule

// File: rtl/key_debounce_array.sv
// Multi-channel key conditioner: one key_debounce_chan per button.
// Ports:
//   clk, rst   : clock, asynchronous active-low reset
//   key_i      : raw button inputs (polarity set by KEY_ACTIVE_LOW)
//   level_o    : debounced pressed levels
//   press_o    : press pulses
//   release_o  : release pulses
//   long_o     : long-press pulses
//   repeat_o   : auto-repeat pulses
module key_debounce_array
    import key_pkg::*;
#(
    parameter int N_KEYS         = 6,
    parameter int DB_CYCLES      = DB_20MS,
    parameter int LONG_CYCLES    = LONG_1S,
    parameter int REPEAT_CYCLES  = RPT_200MS,
    parameter int KEY_ACTIVE_LOW = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [N_KEYS-1:0] key_i,
    output logic [N_KEYS-1:0] level_o,
    output logic [N_KEYS-1:0] press_o,
    output logic [N_KEYS-1:0] release_o,
    output logic [N_KEYS-1:0] long_o,
    output logic [N_KEYS-1:0] repeat_o
);

    for (genvar g = 0; g < N_KEYS; g++) begin : g_chan
        key_debounce_chan #(
            .DB_CYCLES    (DB_CYCLES),
            .LONG_CYCLES  (LONG_CYCLES),
            .REPEAT_CYCLES(REPEAT_CYCLES),
            .ACTIVE_LOW   (KEY_ACTIVE_LOW)
        ) u_chan (
            .clk        (clk),
            .rst        (rst),
            .key        (key_i[g]),
            .level      (level_o[g]),
            .press_pls  (press_o[g]),
            .release_pls(release_o[g]),
            .long_pls   (long_o[g]),
            .repeat_pls (repeat_o[g])
        );
    end

endmodule

// File: tb/tb_key_debounce_array.sv
module tb_key_debounce_array;

    localparam int N    = 2;
    localparam int DB   = 4;
    localparam int LONG = 20;
    localparam int REP  = 5;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic [N-1:0] key = '0;
    logic [N-1:0] key_n;
    logic [N-1:0] lvl_h, prs_h, rel_h, lng_h, rpt_h;
    logic [N-1:0] lvl_l, prs_l, rel_l, lng_l, rpt_l;

    assign key_n = ~key;

    always #5 clk = ~clk;

    key_debounce_array #(.N_KEYS(N), .DB_CYCLES(DB), .LONG_CYCLES(LONG),
                         .REPEAT_CYCLES(REP), .KEY_ACTIVE_LOW(0)) dut_h (
        .clk(clk), .rst(rst), .key_i(key), .level_o(lvl_h), .press_o(prs_h),
        .release_o(rel_h), .long_o(lng_h), .repeat_o(rpt_h));

    key_debounce_array #(.N_KEYS(N), .DB_CYCLES(DB), .LONG_CYCLES(LONG),
                         .REPEAT_CYCLES(REP), .KEY_ACTIVE_LOW(1)) dut_l (
        .clk(clk), .rst(rst), .key_i(key_n), .level_o(lvl_l), .press_o(prs_l),
        .release_o(rel_l), .long_o(lng_l), .repeat_o(rpt_l));

    typedef struct packed {
        logic [N-1:0] lvl, prs, rel, lng, rpt;
    } out_t;

    out_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    bit   done  = 1'b0;

    task automatic check_vec(input string nm, input logic [N-1:0] got, input logic [N-1:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%b exp=%b @%0t", nm, got, exp, $time);
        end
    endtask

    task automatic check_int(input string nm, input int got, input int exp);
        n_cmp++;
        if (got != exp) begin
            n_bad++;
            $display("FAIL %s got=%0d exp=%0d @%0t", nm, got, exp, $time);
        end
    endtask

    // Reference model: a level flips once the synchronised input has
    // disagreed with it for DB+1 consecutive cycles; while pressed, long
    // fires LONG cycles after the press and repeats every REP after that.
    bit m_s1[N], m_s2[N], m_lvl[N];
    int m_run[N], m_t[N];

    initial begin : model
        out_t e;
        bit   pv;
        forever begin
            @(posedge clk);
            e = '0;
            for (int c = 0; c < N; c++) begin
                if (!rst) begin
                    m_s1[c] = 1'b0; m_s2[c] = 1'b0; m_lvl[c] = 1'b0;
                    m_run[c] = 0; m_t[c] = 0;
                end else begin
                    pv = m_s2[c];
                    m_s2[c] = m_s1[c];
                    m_s1[c] = key[c];
                    m_run[c] = (pv != m_lvl[c]) ? m_run[c] + 1 : 0;
                    if (m_run[c] == DB + 1) begin
                        if (m_lvl[c]) e.rel[c] = 1'b1;
                        else          e.prs[c] = 1'b1;
                        m_lvl[c] = ~m_lvl[c];
                        m_run[c] = 0;
                        m_t[c]   = 0;
                    end else if (m_lvl[c]) begin
                        m_t[c]++;
                        if (m_t[c] == LONG) e.lng[c] = 1'b1;
                        if (REP > 0 && m_t[c] > LONG && (m_t[c] - LONG) % REP == 0)
                            e.rpt[c] = 1'b1;
                    end
                    e.lvl[c] = m_lvl[c];
                end
            end
            exp_q.push_back(e);
        end
    end

    initial begin : monitor
        out_t e;
        forever begin
            @(posedge clk);
            #1;
            if (!done) begin
                if (exp_q.size() == 0) begin
                    check_int("sb_empty", 0, 1);
                end else begin
                    e = exp_q.pop_front();
                    check_vec("level_hi",   lvl_h, e.lvl);
                    check_vec("press_hi",   prs_h, e.prs);
                    check_vec("release_hi", rel_h, e.rel);
                    check_vec("long_hi",    lng_h, e.lng);
                    check_vec("repeat_hi",  rpt_h, e.rpt);
                    check_vec("level_lo",   lvl_l, e.lvl);
                    check_vec("press_lo",   prs_l, e.prs);
                    check_vec("release_lo", rel_l, e.rel);
                    check_vec("long_lo",    lng_l, e.lng);
                    check_vec("repeat_lo",  rpt_l, e.rpt);
                end
            end
        end
    end

    task automatic step(input logic [N-1:0] v, input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            key = v;
        end
    endtask

    initial begin : driver
        int lat;
        logic [N-1:0] v;
        int n;

        step(2'b00, 4);
        @(negedge clk); rst = 1'b1;
        step(2'b00, 3);

        // clean press: first sampling edge is edge 0
        @(negedge clk); key = 2'b01;
        lat = -1;
        for (int k = 0; k < 20; k++) begin
            @(posedge clk); #1;
            if (prs_h[0] && lat < 0) lat = k;
        end
        check_int("press_latency", lat, DB + 2);
        step(2'b00, 12);

        // bounce, then settle high
        step(2'b01, 2); step(2'b00, 2); step(2'b01, 2); step(2'b00, 2);
        step(2'b01, 12); step(2'b00, 12);

        // long press with repeats
        step(2'b01, 50); step(2'b00, 15);

        // release glitch while held
        step(2'b01, 10); step(2'b00, 2); step(2'b01, 20); step(2'b00, 12);

        // reset mid-hold on channel 1
        step(2'b10, 12);
        check_vec("pre_rst_level", lvl_h, 2'b10);
        @(negedge clk); rst = 1'b0;
        #1;
        check_vec("rst_level", lvl_h | lvl_l, 2'b00);
        check_vec("rst_pulses", prs_h | rel_h | lng_h | rpt_h | rel_l, 2'b00);
        step(2'b10, 3);
        @(negedge clk); rst = 1'b1;
        step(2'b10, 12); step(2'b00, 12);

        // simultaneous press on both channels
        step(2'b11, 10); step(2'b00, 12);

        // randomized hold/bounce patterns with occasional resets
        for (int i = 0; i < 150; i++) begin
            v = N'($urandom);
            n = $urandom_range(1, 30);
            if ($urandom_range(0, 40) == 0) begin
                @(negedge clk); rst = 1'b0;
                @(negedge clk); rst = 1'b1;
            end
            step(v, n);
        end
        step(2'b00, 12);

        @(negedge clk);
        done = 1'b1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
